// File: rtl/universal_shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_pkg
//  Shared definitions for the universal shift register:
//   - MODE encodings. MODE[2]=0 matches the 194 S[1:0] encoding.
//   - FSM state encoding (IDLE / RUN).
//   - is_shift_mode(): true for the modes a multi-step run repeats.
// ---------------------------------------------------------------------------
package shiftreg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHR  = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_ASR  = 3'b110;
  localparam mode_t MODE_SCLR = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // HOLD, LOAD and SCLR give the same result however often they repeat,
  // so START with those modes is a single operation.
  function automatic logic is_shift_mode(input mode_t mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/universal_shift_register_step.sv
// ---------------------------------------------------------------------------
// shift_step_comb
//  Combinational next-state of the shift register for one step.
//  Ports:
//   q      in  WIDTH  current register contents
//   mode   in  3      operation select (shiftreg_pkg MODE_*)
//   sr     in  1      serial input into the MSB for SHR
//   sl     in  1      serial input into the LSB for SHL
//   d      in  WIDTH  parallel load data
//   q_next out WIDTH  contents after one step
// ---------------------------------------------------------------------------
module shift_step_comb
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    // NOTE: default assignment first so every path drives q_next; no latch.
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {sr, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], sl};
      MODE_LOAD: q_next = d;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_SCLR: q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//  Parametrised 194-style universal shift register with a multi-step engine.
//  With START low, MODE is applied on every rising edge. START with a shift
//  or rotate mode runs AMOUNT steps on consecutive edges (BUSY while more
//  steps remain, one-cycle DONE with the final result).
//  Ports:
//   CLOCK     in   1      rising-edge clock
//   CLEAR     in   1      asynchronous active-low reset; aborts a run
//   START     in   1      request a multi-step operation (ignored when BUSY)
//   MODE      in   3      operation select (shiftreg_pkg MODE_*)
//   AMOUNT    in   CNT_W  number of steps for START
//   SR / SL   in   1      serial inputs for SHR / SHL (sampled live in a run)
//   D         in   WIDTH  parallel load data
//   Q         out  WIDTH  register contents
//   SER_OUT_R out  1      Q[0]
//   SER_OUT_L out  1      Q[WIDTH-1]
//   BUSY      out  1      multi-step run in progress
//   DONE      out  1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_register
  import shiftreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [CNT_W-1:0] AMOUNT,
  input  logic             SR,
  input  logic             SL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SER_OUT_R,
  output logic             SER_OUT_L,
  output logic             BUSY,
  output logic             DONE
);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;       // steps still to run after the current edge
  mode_t            run_mode;  // mode captured when a run is accepted
  mode_t            step_mode;
  logic [WIDTH-1:0] q_next;
  logic             accept_shift;

  assign accept_shift = (state == ST_IDLE) && START && is_shift_mode(MODE);

  // In RUN the captured mode drives every step. A shift START with
  // AMOUNT=0 must leave Q alone, so it is steered to HOLD.
  always_comb begin
    step_mode = MODE;
    if (state == ST_RUN) begin
      step_mode = run_mode;
    end else if (accept_shift && (AMOUNT == '0)) begin
      step_mode = MODE_HOLD;
    end
  end

  shift_step_comb #(
    .WIDTH (WIDTH)
  ) u_step (
    .q      (Q),
    .mode   (step_mode),
    .sr     (SR),
    .sl     (SL),
    .d      (D),
    .q_next (q_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      run_mode <= MODE_HOLD;
      Q        <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      Q <= q_next;
      if (state == ST_IDLE) begin
        // Any accepted START finishes at this edge unless more steps remain.
        DONE <= START;
        if (accept_shift && (AMOUNT > CNT_W'(1))) begin
          state    <= ST_RUN;
          BUSY     <= 1'b1;
          DONE     <= 1'b0;
          cnt      <= AMOUNT - CNT_W'(1);
          run_mode <= MODE;
        end
      end else begin
        cnt  <= cnt - CNT_W'(1);
        DONE <= 1'b0;
        if (cnt == CNT_W'(1)) begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
      end
    end
  end

  assign SER_OUT_R = Q[0];
  assign SER_OUT_L = Q[WIDTH-1];

endmodule
